// File: rtl/d5m_capture_ctrl.sv
// ---------------------------------------------------------------------------
// d5m_capture_ctrl
//
// Frame-capture sequencer for the D5M camera pixel stream. The block arms on
// a start pulse and waits for a frame boundary, so it never captures a partial
// frame. It then tracks pixel and line coordinates and passes only the pixels
// inside a crop window, tagged with SOF/EOL/EOF markers. It captures a
// programmed number of frames, or runs until stopped when cfg_frames is 0.
//
// Pipeline: inputs are registered once (p0). Window and marker decisions are
// made on p0 and registered into the outputs, so o_data/o_valid appear
// 2 sig_clock cycles after the pixel is presented on idata.
//
// Ports:
//   sig_clock, sig_reset_n   pixel clock, asynchronous active-low reset
//   idata, iLValid, iFValid  camera pixel data, line valid, frame valid
//   start, stop              one-cycle pulses: arm capture / end at frame end
//   cfg_x_start/x_end        crop columns, inclusive
//   cfg_y_start/y_end        crop lines, inclusive
//   cfg_frames               frames to capture, 0 = continuous
//   o_data, o_valid          windowed pixel and its qualifier
//   o_sof, o_eol, o_eof      frame-start / line-end / frame-end markers
//   o_x, o_y                 full-frame coordinates of o_data
//   busy, done, err_short    status: not idle / capture complete / short frame
//
// Optional build macro D5M_CAPTURE_TPG_EN: o_data carries the test pattern
// {x[5:0], y[5:0]} instead of camera data, and idata is ignored. Timing,
// o_valid and the markers are unchanged.
// ---------------------------------------------------------------------------
module d5m_capture_ctrl #(
    parameter int DATA_W = 12,
    parameter int CNT_W  = 12,
    parameter int FRM_W  = 8
) (
    input  logic              sig_clock,
    input  logic              sig_reset_n,
    input  logic [DATA_W-1:0] idata,
    input  logic              iLValid,
    input  logic              iFValid,
    input  logic              start,
    input  logic              stop,
    input  logic [CNT_W-1:0]  cfg_x_start,
    input  logic [CNT_W-1:0]  cfg_x_end,
    input  logic [CNT_W-1:0]  cfg_y_start,
    input  logic [CNT_W-1:0]  cfg_y_end,
    input  logic [FRM_W-1:0]  cfg_frames,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_sof,
    output logic              o_eol,
    output logic              o_eof,
    output logic [CNT_W-1:0]  o_x,
    output logic [CNT_W-1:0]  o_y,
    output logic              busy,
    output logic              done,
    output logic              err_short
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT_SOF,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t            r_state;

    logic              r_lv_p0;
    logic              r_fv_p0;
    logic              r_lv_p1;
    logic              r_fv_p1;

    logic [CNT_W-1:0]  r_x;
    logic [CNT_W-1:0]  r_y;
    logic [CNT_W-1:0]  r_xs;
    logic [CNT_W-1:0]  r_xe;
    logic [CNT_W-1:0]  r_ys;
    logic [CNT_W-1:0]  r_ye;
    logic [FRM_W-1:0]  r_frames;
    logic [FRM_W-1:0]  r_fcnt;
    logic              r_stop_pend;
    logic              r_sof_pend;
    logic              r_y_hit;

    logic              w_fv_rise;
    logic              w_fv_fall;
    logic              w_lv_fall;
    logic              w_cap;
    logic              w_pix_vld;
    logic              w_x_last;
    logic              w_y_last;
    logic              w_y_hit_now;
    logic              w_last_frame;
    logic [FRM_W-1:0]  w_fcnt_nx;
    logic [DATA_W-1:0] w_data_p0;

    // Saturating increments: coordinates and the frame counter stick at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc_c(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [FRM_W-1:0] sat_inc_f(input logic [FRM_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // An inverted range (start > end) matches nothing, which empties the window.
    function automatic logic in_win(input logic [CNT_W-1:0] x,  input logic [CNT_W-1:0] y,
                                    input logic [CNT_W-1:0] xs, input logic [CNT_W-1:0] xe,
                                    input logic [CNT_W-1:0] ys, input logic [CNT_W-1:0] ye);
        return (x >= xs) && (x <= xe) && (y >= ys) && (y <= ye);
    endfunction

    // ---- stage p0: registered camera inputs ----
    always_ff @(posedge sig_clock or negedge sig_reset_n) begin
        if (!sig_reset_n) begin
            r_lv_p0 <= 1'b0;
            r_fv_p0 <= 1'b0;
            r_lv_p1 <= 1'b0;
            r_fv_p1 <= 1'b0;
        end else begin
            r_lv_p0 <= iLValid;
            r_fv_p0 <= iFValid;
            r_lv_p1 <= r_lv_p0;
            r_fv_p1 <= r_fv_p0;
        end
    end

`ifdef D5M_CAPTURE_TPG_EN
    logic [11:0] w_tpg;
    assign w_tpg     = {r_x[5:0], r_y[5:0]};
    assign w_data_p0 = DATA_W'(w_tpg);
`else
    logic [DATA_W-1:0] r_data_p0;

    always_ff @(posedge sig_clock) begin
        r_data_p0 <= idata;
    end

    assign w_data_p0 = r_data_p0;
`endif

    assign w_fv_rise    = r_fv_p0 & ~r_fv_p1;
    assign w_fv_fall    = ~r_fv_p0 & r_fv_p1;
    assign w_lv_fall    = ~r_lv_p0 & r_lv_p1;
    assign w_cap        = (r_state == S_CAPTURE);
    assign w_pix_vld    = w_cap & r_lv_p0 & in_win(r_x, r_y, r_xs, r_xe, r_ys, r_ye);
    assign w_x_last     = (r_x == r_xe);
    assign w_y_last     = (r_y == r_ye);
    assign w_y_hit_now  = r_lv_p0 & w_y_last;
    assign w_fcnt_nx    = sat_inc_f(r_fcnt);
    // A stop arriving on the frame-end cycle itself joins the normal DONE path.
    assign w_last_frame = ((r_frames != '0) && (w_fcnt_nx == r_frames)) || r_stop_pend || stop;

    // Coordinates of the pixel currently in p0. Held at 0 outside CAPTURE,
    // so every captured frame starts at (0,0).
    always_ff @(posedge sig_clock or negedge sig_reset_n) begin
        if (!sig_reset_n) begin
            r_x <= '0;
            r_y <= '0;
        end else if (!w_cap) begin
            r_x <= '0;
            r_y <= '0;
        end else if (r_lv_p0) begin
            r_x <= sat_inc_c(r_x);
        end else if (w_lv_fall) begin
            r_x <= '0;
            r_y <= sat_inc_c(r_y);
        end
    end

    // Capture sequencer with registered status outputs.
    always_ff @(posedge sig_clock or negedge sig_reset_n) begin
        if (!sig_reset_n) begin
            r_state     <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_short   <= 1'b0;
            r_fcnt      <= '0;
            r_stop_pend <= 1'b0;
            r_sof_pend  <= 1'b0;
            r_y_hit     <= 1'b0;
            r_xs        <= '0;
            r_xe        <= '0;
            r_ys        <= '0;
            r_ye        <= '0;
            r_frames    <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_stop_pend <= 1'b0;
                    if (start) begin
                        r_state   <= S_ARM;
                        busy      <= 1'b1;
                        err_short <= 1'b0;
                        r_fcnt    <= '0;
                    end
                end
                S_ARM: begin
                    if (stop) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end else if (!r_fv_p0) begin
                        // Frame valid low: the next rising edge is a whole frame.
                        r_state <= S_WAIT_SOF;
                    end
                end
                S_WAIT_SOF: begin
                    if (stop) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end else if (w_fv_rise) begin
                        r_xs       <= cfg_x_start;
                        r_xe       <= cfg_x_end;
                        r_ys       <= cfg_y_start;
                        r_ye       <= cfg_y_end;
                        r_frames   <= cfg_frames;
                        r_sof_pend <= 1'b1;
                        r_y_hit    <= 1'b0;
                        r_state    <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (stop)
                        r_stop_pend <= 1'b1;
                    if (w_pix_vld)
                        r_sof_pend <= 1'b0;
                    if (w_y_hit_now)
                        r_y_hit <= 1'b1;
                    if (w_fv_fall) begin
                        r_fcnt <= w_fcnt_nx;
                        if (!(r_y_hit || w_y_hit_now))
                            err_short <= 1'b1;
                        if (w_last_frame) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state <= S_WAIT_SOF;
                        end
                    end
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    busy        <= 1'b0;
                    r_stop_pend <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // ---- stage p1: windowed output ----
    // Data and coordinates only move on valid pixels, so they read 0 after
    // reset and otherwise hold the last emitted pixel.
    always_ff @(posedge sig_clock or negedge sig_reset_n) begin
        if (!sig_reset_n) begin
            o_valid <= 1'b0;
            o_sof   <= 1'b0;
            o_eol   <= 1'b0;
            o_eof   <= 1'b0;
            o_data  <= '0;
            o_x     <= '0;
            o_y     <= '0;
        end else begin
            o_valid <= w_pix_vld;
            o_sof   <= w_pix_vld & r_sof_pend;
            o_eol   <= w_pix_vld & w_x_last;
            o_eof   <= w_pix_vld & w_x_last & w_y_last;
            if (w_pix_vld) begin
                o_data <= w_data_p0;
                o_x    <= r_x;
                o_y    <= r_y;
            end
        end
    end

endmodule

// File: tb/tb_d5m_capture_ctrl.sv
module tb_d5m_capture_ctrl;

    localparam int DATA_W = 12;
    localparam int CNT_W  = 12;
    localparam int FRM_W  = 8;

    logic              sig_clock = 1'b0;
    logic              sig_reset_n = 1'b0;
    logic [DATA_W-1:0] idata = '0;
    logic              iLValid = 1'b0;
    logic              iFValid = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [CNT_W-1:0]  cfg_x_start = '0;
    logic [CNT_W-1:0]  cfg_x_end = '0;
    logic [CNT_W-1:0]  cfg_y_start = '0;
    logic [CNT_W-1:0]  cfg_y_end = '0;
    logic [FRM_W-1:0]  cfg_frames = '0;
    logic [DATA_W-1:0] o_data;
    logic              o_valid, o_sof, o_eol, o_eof;
    logic [CNT_W-1:0]  o_x, o_y;
    logic              busy, done, err_short;

    d5m_capture_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W), .FRM_W(FRM_W)) dut (
        .sig_clock(sig_clock), .sig_reset_n(sig_reset_n),
        .idata(idata), .iLValid(iLValid), .iFValid(iFValid),
        .start(start), .stop(stop),
        .cfg_x_start(cfg_x_start), .cfg_x_end(cfg_x_end),
        .cfg_y_start(cfg_y_start), .cfg_y_end(cfg_y_end),
        .cfg_frames(cfg_frames),
        .o_data(o_data), .o_valid(o_valid),
        .o_sof(o_sof), .o_eol(o_eol), .o_eof(o_eof),
        .o_x(o_x), .o_y(o_y),
        .busy(busy), .done(done), .err_short(err_short)
    );

    always #5 sig_clock = ~sig_clock;

    int total = 0;
    int bad   = 0;

    // Per-scenario observations gathered while frames are driven.
    int          st_valid, st_sof, st_sof_x, st_sof_y, st_eol, st_eof, st_eof_x, st_eof_y;
    int          st_done, st_dmis, st_mark_bad, st_rst_nz;
    logic [11:0] st_d32;

    // Input presented on the previous clock; with 2-cycle latency this is
    // what the outputs must describe after the current clock.
    logic p_lv = 1'b0;
    int   p_x = 0;
    int   p_y = 0;

    function automatic logic [11:0] pix(input int x, input int y);
        return 12'((y * 64 + x) ^ 32'h0000_0A5A);
    endfunction

    function automatic logic [11:0] exp_out(input int x, input int y);
`ifdef D5M_CAPTURE_TPG_EN
        return {x[5:0], y[5:0]};
`else
        return pix(x, y);
`endif
    endfunction

    task automatic clr_stats();
        st_valid = 0; st_sof = 0; st_sof_x = -1; st_sof_y = -1;
        st_eol = 0; st_eof = 0; st_eof_x = -1; st_eof_y = -1;
        st_done = 0; st_dmis = 0; st_mark_bad = 0; st_rst_nz = 0;
        st_d32 = '0;
    endtask

    task automatic step(input logic fv, input logic lv, input int x, input int y);
        iFValid = fv;
        iLValid = lv;
        idata   = lv ? pix(x, y) : '0;
        @(posedge sig_clock);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        if (o_valid) begin
            st_valid++;
            if (!p_lv || o_x !== CNT_W'(p_x) || o_y !== CNT_W'(p_y) || o_data !== exp_out(p_x, p_y))
                st_dmis++;
            if (p_x == 3 && p_y == 2)
                st_d32 = o_data;
            if (o_sof) begin st_sof++; st_sof_x = p_x; st_sof_y = p_y; end
            if (o_eol) st_eol++;
            if (o_eof) begin st_eof++; st_eof_x = p_x; st_eof_y = p_y; end
        end else if (o_sof || o_eol || o_eof) begin
            st_mark_bad++;
        end
        if (done)
            st_done++;
        p_lv = lv;
        p_x  = x;
        p_y  = y;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 0, 0);
    endtask

    // One camera frame of nl lines by np pixels. Optional start/stop pulses and
    // a 3-cycle reset can be placed at the first pixel of a chosen line.
    task automatic frame(input int nl, input int np, input int start_ln, input int stop_ln,
                         input int rst_ln);
        repeat (2) step(1'b1, 1'b0, 0, 0);
        for (int l = 0; l < nl; l++) begin
            for (int x = 0; x < np; x++) begin
                if (x == 0 && l == start_ln) start = 1'b1;
                if (x == 0 && l == stop_ln)  stop  = 1'b1;
                if (x == 0 && l == rst_ln) begin
                    sig_reset_n = 1'b0;
                    #1;
                    if (o_valid || o_sof || o_eol || o_eof || busy || done || err_short ||
                        o_data !== '0 || o_x !== '0 || o_y !== '0)
                        st_rst_nz++;
                end
                if (x == 3 && l == rst_ln) sig_reset_n = 1'b1;
                step(1'b1, 1'b1, x, l);
            end
            repeat (3) step(1'b1, 1'b0, 0, 0);
        end
        repeat (6) step(1'b0, 1'b0, 0, 0);
    endtask

    task automatic set_win(input int xs, input int xe, input int ys, input int ye, input int nf);
        cfg_x_start = CNT_W'(xs); cfg_x_end = CNT_W'(xe);
        cfg_y_start = CNT_W'(ys); cfg_y_end = CNT_W'(ye);
        cfg_frames  = FRM_W'(nf);
    endtask

    task automatic test_reset();
        sig_reset_n = 1'b0;
        idle(3);
        sig_reset_n = 1'b1;
        idle(2);
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", o_valid); end
        total++; if ({o_sof, o_eol, o_eof} !== 3'b000) begin bad++; $display("FAIL rst_markers: got %b want 000", {o_sof, o_eol, o_eof}); end
        total++; if ({busy, done, err_short} !== 3'b000) begin bad++; $display("FAIL rst_status: got %b want 000", {busy, done, err_short}); end
        total++; if (o_data !== '0) begin bad++; $display("FAIL rst_data: got %h want 000", o_data); end
        total++; if ({o_x, o_y} !== '0) begin bad++; $display("FAIL rst_xy: got %0d,%0d want 0,0", o_x, o_y); end
    endtask

    task automatic test_single_frame();
        set_win(2, 5, 1, 2, 1);
        clr_stats();
        frame(4, 8, 1, -1, -1);
        total++; if (st_valid !== 0) begin bad++; $display("FAIL t1_partial_valid: got %0d want 0", st_valid); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL t1_armed_busy: got %b want 1", busy); end
        clr_stats();
        frame(4, 8, -1, -1, -1);
        total++; if (st_valid !== 8) begin bad++; $display("FAIL t1_valid: got %0d want 8", st_valid); end
        total++; if (st_dmis !== 0) begin bad++; $display("FAIL t1_data: got %0d bad pixels want 0", st_dmis); end
        total++; if (st_sof !== 1 || st_sof_x !== 2 || st_sof_y !== 1) begin bad++; $display("FAIL t1_sof: got n=%0d (%0d,%0d) want n=1 (2,1)", st_sof, st_sof_x, st_sof_y); end
        total++; if (st_eol !== 2) begin bad++; $display("FAIL t1_eol: got %0d want 2", st_eol); end
        total++; if (st_eof !== 1 || st_eof_x !== 5 || st_eof_y !== 2) begin bad++; $display("FAIL t1_eof: got n=%0d (%0d,%0d) want n=1 (5,2)", st_eof, st_eof_x, st_eof_y); end
        total++; if (st_mark_bad !== 0) begin bad++; $display("FAIL t1_markers_unqualified: got %0d want 0", st_mark_bad); end
`ifdef D5M_CAPTURE_TPG_EN
        total++; if (st_d32 !== 12'h0C2) begin bad++; $display("FAIL t1_pix32: got %h want 0c2", st_d32); end
`else
        total++; if (st_d32 !== 12'hAD9) begin bad++; $display("FAIL t1_pix32: got %h want ad9", st_d32); end
`endif
        total++; if (st_done !== 1) begin bad++; $display("FAIL t1_done: got %0d pulses want 1", st_done); end
        total++; if (busy !== 1'b0 || err_short !== 1'b0) begin bad++; $display("FAIL t1_end_status: got busy=%b err=%b want 0 0", busy, err_short); end
    endtask

    task automatic test_multi_frame();
        set_win(2, 5, 1, 2, 3);
        start = 1'b1;
        idle(3);
        clr_stats();
        repeat (3) frame(4, 8, -1, -1, -1);
        total++; if (st_valid !== 24) begin bad++; $display("FAIL t2_valid: got %0d want 24", st_valid); end
        total++; if (st_sof !== 3 || st_eof !== 3) begin bad++; $display("FAIL t2_sof_eof: got %0d/%0d want 3/3", st_sof, st_eof); end
        total++; if (st_done !== 1 || busy !== 1'b0) begin bad++; $display("FAIL t2_done: got done=%0d busy=%b want 1 0", st_done, busy); end
        total++; if (st_dmis !== 0) begin bad++; $display("FAIL t2_data: got %0d bad pixels want 0", st_dmis); end
        clr_stats();
        frame(4, 8, -1, -1, -1);
        total++; if (st_valid !== 0 || st_done !== 0) begin bad++; $display("FAIL t2_fourth: got valid=%0d done=%0d want 0 0", st_valid, st_done); end
    endtask

    task automatic test_continuous_stop();
        set_win(2, 5, 1, 2, 0);
        start = 1'b1;
        idle(3);
        clr_stats();
        frame(4, 8, -1, -1, -1);
        total++; if (st_done !== 0 || busy !== 1'b1) begin bad++; $display("FAIL t3_running: got done=%0d busy=%b want 0 1", st_done, busy); end
        frame(4, 8, -1, 1, -1);
        total++; if (st_valid !== 16 || st_eof !== 2) begin bad++; $display("FAIL t3_valid: got valid=%0d eof=%0d want 16 2", st_valid, st_eof); end
        total++; if (st_done !== 1 || busy !== 1'b0) begin bad++; $display("FAIL t3_done: got done=%0d busy=%b want 1 0", st_done, busy); end
        clr_stats();
        frame(4, 8, -1, -1, -1);
        total++; if (st_valid !== 0) begin bad++; $display("FAIL t3_after_stop: got %0d want 0", st_valid); end
    endtask

    task automatic test_stop_waiting();
        set_win(2, 5, 1, 2, 1);
        start = 1'b1;
        idle(2);
        stop = 1'b1;
        idle(2);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t4_stop_busy: got %b want 0", busy); end
        clr_stats();
        frame(4, 8, -1, -1, -1);
        total++; if (st_valid !== 0 || st_done !== 0) begin bad++; $display("FAIL t4_no_capture: got valid=%0d done=%0d want 0 0", st_valid, st_done); end
    endtask

    task automatic test_short_frame();
        set_win(2, 5, 1, 3, 1);
        start = 1'b1;
        idle(3);
        clr_stats();
        frame(2, 8, -1, -1, -1);
        total++; if (st_valid !== 4 || st_eof !== 0) begin bad++; $display("FAIL t5_valid: got valid=%0d eof=%0d want 4 0", st_valid, st_eof); end
        total++; if (st_done !== 1) begin bad++; $display("FAIL t5_done: got %0d want 1", st_done); end
        idle(4);
        total++; if (err_short !== 1'b1) begin bad++; $display("FAIL t5_err_sticky: got %b want 1", err_short); end
        start = 1'b1;
        idle(1);
        total++; if (err_short !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL t5_err_clear: got err=%b busy=%b want 0 1", err_short, busy); end
        stop = 1'b1;
        idle(2);
    endtask

    task automatic test_reset_mid_capture();
        set_win(2, 5, 1, 2, 0);
        start = 1'b1;
        idle(3);
        clr_stats();
        frame(4, 8, -1, -1, 2);
        total++; if (st_rst_nz !== 0) begin bad++; $display("FAIL t6_rst_outputs: got %0d nonzero samples want 0", st_rst_nz); end
        total++; if (st_valid !== 4 || busy !== 1'b0 || st_done !== 0) begin bad++; $display("FAIL t6_after_rst: got valid=%0d busy=%b done=%0d want 4 0 0", st_valid, busy, st_done); end
        set_win(2, 5, 1, 2, 1);
        start = 1'b1;
        idle(3);
        clr_stats();
        frame(4, 8, -1, -1, -1);
        total++; if (st_valid !== 8 || st_sof !== 1 || st_done !== 1) begin bad++; $display("FAIL t6_resume: got valid=%0d sof=%0d done=%0d want 8 1 1", st_valid, st_sof, st_done); end
        total++; if (st_dmis !== 0 || busy !== 1'b0) begin bad++; $display("FAIL t6_resume_data: got dmis=%0d busy=%b want 0 0", st_dmis, busy); end
    endtask

    initial begin
        clr_stats();
        test_reset();
        test_single_frame();
        test_multi_frame();
        test_continuous_stop();
        test_stop_waiting();
        test_short_frame();
        test_reset_mid_capture();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/d5m_capture_ctrl.md
Name: d5m_capture_ctrl

Overview:
- Frame-capture sequencer for the D5M camera pixel stream: 12-bit pixel data qualified by line-valid and frame-valid.
- Arms on command and synchronises to the next frame boundary.
- Tracks pixel/line coordinates, applies a crop window and captures a programmed number of frames (or runs continuously).
- Sits between the camera input interface and the downstream video/AXI-stream packer; emits windowed pixels with SOF/EOL/EOF markers and status.

Parameters:
- DATA_W, 12, pixel data width
- CNT_W, 12, width of x/y coordinate counters and window config fields
- FRM_W, 8, width of frame-count config and counter

Ports:
- sig_clock  input  1  pixel clock
- sig_reset_n  input  1  asynchronous active-low reset
- idata  input  DATA_W  camera pixel data
- iLValid  input  1  camera line valid
- iFValid  input  1  camera frame valid
- start  input  1  one-cycle pulse: arm capture
- stop  input  1  one-cycle pulse: end capture at next frame end
- cfg_x_start, cfg_x_end  input  CNT_W  crop columns, inclusive
- cfg_y_start, cfg_y_end  input  CNT_W  crop lines, inclusive
- cfg_frames  input  FRM_W  frames to capture; 0 = continuous
- o_data  output  DATA_W  windowed pixel
- o_valid  output  1  o_data valid
- o_sof, o_eol, o_eof  output  1  first pixel of frame / last pixel of line / last pixel of frame, qualified by o_valid
- o_x, o_y  output  CNT_W  coordinates of o_data within the full frame
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse when the programmed frame count completes
- err_short  output  1  sticky: a frame ended before cfg_y_end was reached; cleared by start

Behaviour:
- Reset: all outputs 0; FSM to IDLE; counters and shadow config to 0.
- Input stage: idata, iLValid and iFValid registered once. Edges are detected on the registered copies.
- Output latency: fixed 2 sig_clock cycles from pixel at input to o_data/o_valid.
- FSM states:
  - IDLE: start -> ARM; err_short cleared; frame counter cleared.
  - ARM: wait for iFValid low. If iFValid is already low, go to WAIT_SOF next cycle. Prevents capturing a partial frame.
  - WAIT_SOF: on iFValid rising edge, latch cfg_* into shadow registers -> CAPTURE.
  - CAPTURE: on iFValid falling edge, increment frame counter, then:
    - If (cfg_frames != 0 and count == cfg_frames) or stop is pending -> DONE.
    - Otherwise -> WAIT_SOF.
  - DONE: assert done for 1 cycle -> IDLE.
- stop: latched as pending in any non-IDLE state. In ARM or WAIT_SOF it goes to IDLE immediately with no done pulse. stop in IDLE is ignored.
- start while busy: ignored.
- Counters, in CAPTURE only:
  - x increments per pixel while iLValid is high; cleared on iLValid falling edge.
  - y increments on iLValid falling edge; cleared at frame start.
  - Both saturate at all-ones; no wrap.
- Window: o_valid = iLValid & (x_start <= x <= x_end) & (y_start <= y <= y_end), using shadow values.
  - If x_start > x_end or y_start > y_end, no pixels pass. The frame still counts.
- Markers:
  - o_sof on the first valid pixel of each frame.
  - o_eol when x == x_end.
  - o_eof when x == x_end and y == y_end.
- err_short: set at iFValid falling edge if y never reached y_end during the frame. The frame still counts.
- Line ends before x_end: no o_eol for that line; no error.
- Simultaneous events:
  - stop on the same cycle as the final frame end -> single DONE.
  - start on the same cycle as DONE -> ignored.
- Config changes mid-frame take effect at the next frame start.
- Reset asserted mid-frame clears everything immediately. After release the block is IDLE and requires a new start.

Optional Feature:
- Macro: D5M_CAPTURE_TPG_EN
- Defined: o_data is replaced by the pattern {x[5:0], y[5:0]}, zero-extended or truncated to DATA_W. Timing, o_valid and markers are unchanged. idata is ignored.
- Undefined: o_data is the registered idata.

Test Plan:
- Single frame 8x4, window x 2..5, y 1..2, cfg_frames=1, start mid-frame -> current frame skipped. Next frame gives 8 o_valid pixels, o_sof at (2,1), o_eol at x=5 each line, o_eof at (5,2), done pulse after iFValid falls, busy low.
- cfg_frames=3 -> exactly 3 frames of windowed output, one done pulse, 4th frame produces no o_valid.
- cfg_frames=0 continuous; stop asserted mid-frame 2 -> frame 2 completes fully, then done, IDLE.
- Frame with only 2 lines, cfg_y_end=3 -> err_short set and held; no o_eof; cleared on next start.
- sig_reset_n low for 3 cycles during CAPTURE -> all outputs 0 immediately, IDLE after release. start then resumes at the next frame boundary.
- With D5M_CAPTURE_TPG_EN: pixel (3,2) -> o_data = 12'h0C2, 2-cycle latency preserved.
